// File: rtl/alu_ctrl_mc_if.sv
// alu_ctrl_mc_if: handshake bundle between the ID/control stage and the
// multi-cycle ALU-control block.
//   master: the issuing core side (drives operation, consumes result)
//   slave : the alu_ctrl_mc block
// Request : in_valid/in_ready, alu_op, funct, a, b
// Response: out_valid/out_ready, alu_ctrl, result, result_hi, cond,
//           illegal, div0
interface alu_ctrl_mc_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       alu_op;
  logic [5:0]       funct;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [3:0]       alu_ctrl;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] result_hi;
  logic             cond;
  logic             illegal;
  logic             div0;

  modport master (
    output in_valid, alu_op, funct, a, b, out_ready,
    input  in_ready, out_valid, alu_ctrl, result, result_hi, cond, illegal, div0
  );

  modport slave (
    input  in_valid, alu_op, funct, a, b, out_ready,
    output in_ready, out_valid, alu_ctrl, result, result_hi, cond, illegal, div0
  );
endinterface

// File: rtl/alu_ctrl_mc.sv
// alu_ctrl_mc: decodes alu_op/funct into the 4-bit ALU control code and
// executes the operation. Single-cycle ops finish one edge after acceptance;
// multu/divu iterate one bit per cycle (shift-add / restoring divide) and
// finish WIDTH+1 cycles after acceptance.
// Ports:
//   clk   - rising-edge clock
//   rst_n - synchronous active-low reset
//   bus   - alu_ctrl_mc_if.slave: in_valid/in_ready request with alu_op,
//           funct, a, b; out_valid/out_ready response with alu_ctrl, result,
//           result_hi, cond, illegal, div0
module alu_ctrl_mc #(
  parameter int WIDTH     = 32,
  parameter bit MULDIV_EN = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,
  alu_ctrl_mc_if.slave  bus
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] STEP_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] STEP_ONE  = CW'(1);

  localparam logic [3:0] C_AND  = 4'b0000;
  localparam logic [3:0] C_OR   = 4'b0001;
  localparam logic [3:0] C_ADD  = 4'b0010;
  localparam logic [3:0] C_SUB  = 4'b0110;
  localparam logic [3:0] C_SLT  = 4'b0111;
  localparam logic [3:0] C_BEQ  = 4'b1000;
  localparam logic [3:0] C_BNE  = 4'b1001;
  localparam logic [3:0] C_NOR  = 4'b1100;
  localparam logic [3:0] C_XOR  = 4'b1101;
  localparam logic [3:0] C_MULU = 4'b1110;
  localparam logic [3:0] C_DIVU = 4'b1111;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    step_q, step_d;
  logic [3:0]       ctrl_q, ctrl_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;   // multiplicand / divisor
  logic [WIDTH-1:0] hi_q, hi_d;       // product high / remainder
  logic [WIDTH-1:0] lo_q, lo_d;       // multiplier->product low / dividend->quotient
  logic             cond_q, cond_d;
  logic             illegal_q, illegal_d;
  logic             div0_q, div0_d;

  // Decode
  logic [3:0] dec_ctrl;
  logic       dec_ill;

  always_comb begin
    dec_ctrl = C_ADD;
    dec_ill  = 1'b0;
    case (bus.alu_op)
      2'b00: dec_ctrl = C_ADD;
      2'b01: dec_ctrl = C_BEQ;
      2'b11: dec_ctrl = C_BNE;
      default: begin
        case (bus.funct)
          6'b100000: dec_ctrl = C_ADD;
          6'b100010: dec_ctrl = C_SUB;
          6'b100100: dec_ctrl = C_AND;
          6'b100101: dec_ctrl = C_OR;
          6'b100110: dec_ctrl = C_XOR;
          6'b100111: dec_ctrl = C_NOR;
          6'b101010: dec_ctrl = C_SLT;
          6'b011001: if (MULDIV_EN) dec_ctrl = C_MULU; else dec_ill = 1'b1;
          6'b011011: if (MULDIV_EN) dec_ctrl = C_DIVU; else dec_ill = 1'b1;
          default:   dec_ill = 1'b1;
        endcase
      end
    endcase
  end

  // Single-cycle execute on the live operands at acceptance
  logic signed [WIDTH-1:0] a_s, b_s;
  logic        [WIDTH-1:0] alu_res;
  logic                    alu_cond;

  assign a_s = bus.a;
  assign b_s = bus.b;

  always_comb begin
    alu_res = bus.a + bus.b;
    case (dec_ctrl)
      C_SUB, C_BEQ, C_BNE: alu_res = bus.a - bus.b;
      C_AND: alu_res = bus.a & bus.b;
      C_OR:  alu_res = bus.a | bus.b;
      C_XOR: alu_res = bus.a ^ bus.b;
      C_NOR: alu_res = ~(bus.a | bus.b);
      C_SLT: alu_res = {{(WIDTH-1){1'b0}}, (a_s < b_s)};
      default: alu_res = bus.a + bus.b;
    endcase
    case (dec_ctrl)
      C_BEQ:   alu_cond = (bus.a == bus.b);
      C_BNE:   alu_cond = (bus.a != bus.b);
      default: alu_cond = (alu_res == '0);
    endcase
  end

  // Iterative step: shift-add multiply (LSB first) and restoring divide.
  // The divide compares at WIDTH+1 bits so b==0 always "subtracts",
  // which naturally yields quotient all-ones and remainder = a.
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_diff;
  logic             div_ge;

  assign mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
  assign div_shift = {hi_q, lo_q[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, opnd_q};
  assign div_ge    = (div_shift >= {1'b0, opnd_q});

  always_comb begin
    state_d   = state_q;
    step_d    = step_q;
    ctrl_d    = ctrl_q;
    opnd_d    = opnd_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    cond_d    = cond_q;
    illegal_d = illegal_q;
    div0_d    = div0_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          ctrl_d    = dec_ctrl;
          illegal_d = dec_ill;
          opnd_d    = bus.b;
          hi_d      = '0;
          if (dec_ctrl == C_MULU || dec_ctrl == C_DIVU) begin
            state_d = BUSY;
            step_d  = '0;
            lo_d    = bus.a;
            cond_d  = 1'b0;
            div0_d  = (dec_ctrl == C_DIVU) && (bus.b == '0);
          end else begin
            state_d = DONE;
            lo_d    = alu_res;
            cond_d  = alu_cond;
            div0_d  = 1'b0;
          end
        end
      end
      BUSY: begin
        step_d = step_q + STEP_ONE;
        if (ctrl_q == C_DIVU) begin
          hi_d = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
          lo_d = {lo_q[WIDTH-2:0], div_ge};
        end else begin
          hi_d = mul_sum[WIDTH:1];
          lo_d = {mul_sum[0], lo_q[WIDTH-1:1]};
        end
        if (step_q == STEP_LAST) begin
          state_d = DONE;
          cond_d  = (lo_d == '0);
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d   = IDLE;
          ctrl_d    = C_ADD;
          cond_d    = 1'b0;
          illegal_d = 1'b0;
          div0_d    = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      step_q    <= '0;
      ctrl_q    <= C_ADD;
      opnd_q    <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      cond_q    <= 1'b0;
      illegal_q <= 1'b0;
      div0_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      step_q    <= step_d;
      ctrl_q    <= ctrl_d;
      opnd_q    <= opnd_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      cond_q    <= cond_d;
      illegal_q <= illegal_d;
      div0_q    <= div0_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.alu_ctrl  = ctrl_q;
  assign bus.result    = lo_q;
  assign bus.result_hi = hi_q;
  assign bus.cond      = cond_q;
  assign bus.illegal   = illegal_q;
  assign bus.div0      = div0_q;

endmodule

// File: tb/tb_alu_ctrl_mc.sv
module tb_alu_ctrl_mc;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        sel;          // 0: 32-bit DUT with mul/div, 1: 8-bit DUT without
  logic        drv_valid, drv_out_ready;
  logic [1:0]  drv_op;
  logic [5:0]  drv_f;
  logic [31:0] drv_a, drv_b;

  alu_ctrl_mc_if #(.WIDTH(32)) bus32();
  alu_ctrl_mc_if #(.WIDTH(8))  bus8();

  assign bus32.in_valid  = drv_valid & ~sel;
  assign bus32.out_ready = drv_out_ready & ~sel;
  assign bus32.alu_op    = drv_op;
  assign bus32.funct     = drv_f;
  assign bus32.a         = drv_a;
  assign bus32.b         = drv_b;
  assign bus8.in_valid   = drv_valid & sel;
  assign bus8.out_ready  = drv_out_ready & sel;
  assign bus8.alu_op     = drv_op;
  assign bus8.funct      = drv_f;
  assign bus8.a          = drv_a[7:0];
  assign bus8.b          = drv_b[7:0];

  alu_ctrl_mc #(.WIDTH(32), .MULDIV_EN(1'b1)) u_dut32 (.clk(clk), .rst_n(rst_n), .bus(bus32));
  alu_ctrl_mc #(.WIDTH(8),  .MULDIV_EN(1'b0)) u_dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8));

  logic        obs_ir, obs_ov, obs_cond, obs_ill, obs_dz;
  logic [3:0]  obs_ctrl;
  logic [31:0] obs_res, obs_hi;

  always_comb begin
    obs_ir   = sel ? bus8.in_ready  : bus32.in_ready;
    obs_ov   = sel ? bus8.out_valid : bus32.out_valid;
    obs_cond = sel ? bus8.cond      : bus32.cond;
    obs_ill  = sel ? bus8.illegal   : bus32.illegal;
    obs_dz   = sel ? bus8.div0      : bus32.div0;
    obs_ctrl = sel ? bus8.alu_ctrl  : bus32.alu_ctrl;
    obs_res  = sel ? {24'b0, bus8.result}    : bus32.result;
    obs_hi   = sel ? {24'b0, bus8.result_hi} : bus32.result_hi;
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference: plain arithmetic on integers from the op table.
  function automatic void ref_op(input int w, input bit md, input logic [1:0] op,
                                 input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                                 output logic [3:0] ctrl, output logic [31:0] res,
                                 output logic [31:0] hi, output bit cnd, output bit ill,
                                 output bit dz, output int lat);
    longint unsigned m, ua, ub, r, h;
    longint sa, sb;
    m  = 64'd1 << w;
    ua = {32'b0, a} & (m - 1);
    ub = {32'b0, b} & (m - 1);
    sa = (ua >= m / 2) ? longint'(ua) - longint'(m) : longint'(ua);
    sb = (ub >= m / 2) ? longint'(ub) - longint'(m) : longint'(ub);
    ill = 0; dz = 0; h = 0; lat = 1; ctrl = 4'b0010; r = ua + ub;
    case (op)
      2'b00: begin ctrl = 4'b0010; r = ua + ub; end
      2'b01: begin ctrl = 4'b1000; r = ua - ub; end
      2'b11: begin ctrl = 4'b1001; r = ua - ub; end
      default: begin
        case (f)
          6'h20: begin ctrl = 4'b0010; r = ua + ub; end
          6'h22: begin ctrl = 4'b0110; r = ua - ub; end
          6'h24: begin ctrl = 4'b0000; r = ua & ub; end
          6'h25: begin ctrl = 4'b0001; r = ua | ub; end
          6'h26: begin ctrl = 4'b1101; r = ua ^ ub; end
          6'h27: begin ctrl = 4'b1100; r = ~(ua | ub); end
          6'h2A: begin ctrl = 4'b0111; r = (sa < sb) ? 1 : 0; end
          6'h19: if (md) begin
                   ctrl = 4'b1110; r = ua * ub; h = (ua * ub) >> w; lat = w + 1;
                 end else ill = 1;
          6'h1B: if (md) begin
                   ctrl = 4'b1111; lat = w + 1;
                   if (ub == 0) begin r = m - 1; h = ua; dz = 1; end
                   else begin r = ua / ub; h = ua % ub; end
                 end else ill = 1;
          default: ill = 1;
        endcase
      end
    endcase
    res = 32'(r & (m - 1));
    hi  = 32'(h & (m - 1));
    if (op == 2'b01)      cnd = (ua == ub);
    else if (op == 2'b11) cnd = (ua != ub);
    else                  cnd = (res == 0);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_out_valid"}, obs_ov, 0);
    chk({tag, "_in_ready"},  obs_ir, 1);
    chk({tag, "_outs"}, {obs_ctrl, obs_cond, obs_ill, obs_dz}, {4'b0010, 3'b000});
    chk({tag, "_result"}, {obs_hi, obs_res}, 64'd0);
  endtask

  task automatic run_op(input logic [1:0] op, input logic [5:0] f,
                        input logic [31:0] a, input logic [31:0] b, input int hold);
    logic [3:0]  e_ctrl;
    logic [31:0] e_res, e_hi;
    bit          e_cond, e_ill, e_dz;
    int          e_lat, cnt;
    ref_op(sel ? 8 : 32, !sel, op, f, a, b, e_ctrl, e_res, e_hi, e_cond, e_ill, e_dz, e_lat);
    chk("in_ready_idle", obs_ir, 1);
    drv_valid = 1; drv_op = op; drv_f = f; drv_a = a; drv_b = b;
    tick();
    // scramble operands after acceptance; the op in flight must not see them
    drv_valid = 0; drv_a = $urandom; drv_b = $urandom; drv_f = 6'($urandom);
    cnt = 1;
    while (!obs_ov && cnt <= e_lat + 5) begin
      chk("busy_in_ready", obs_ir, 0);
      drv_valid = 1'($urandom);
      tick();
      cnt++;
    end
    drv_valid = 0;
    chk("latency", cnt, e_lat);
    for (int i = 0; i <= hold; i++) begin
      if (i > 0) begin
        tick();
        chk("hold_in_ready", obs_ir, 0);
      end
      chk("out_valid", obs_ov, 1);
      chk("alu_ctrl", obs_ctrl, e_ctrl);
      chk("result", obs_res, e_res);
      chk("result_hi", obs_hi, e_hi);
      chk("flags", {obs_cond, obs_ill, obs_dz}, {e_cond, e_ill, e_dz});
    end
    drv_out_ready = 1;
    tick();
    drv_out_ready = 0;
    chk("ov_drop", obs_ov, 0);
    chk("ready_back", obs_ir, 1);
    chk("flags_clr", {obs_ctrl, obs_cond, obs_ill, obs_dz}, {4'b0010, 3'b000});
  endtask

  // Accept an op, wait `at` edges, then reset with in_valid still high.
  task automatic abort_op(input logic [1:0] op, input logic [5:0] f,
                          input logic [31:0] a, input logic [31:0] b, input int at);
    bit seen;
    drv_valid = 1; drv_op = op; drv_f = f; drv_a = a; drv_b = b;
    tick();
    drv_valid = 0;
    for (int i = 0; i < at; i++) tick();
    rst_n = 0; drv_valid = 1; drv_out_ready = 1;
    tick();
    rst_n = 1; drv_valid = 0; drv_out_ready = 0;
    chk_reset("abort");
    seen = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (obs_ov) seen = 1;
    end
    chk("abort_no_out_valid", seen, 0);
  endtask

  logic [5:0] flist [10] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h19, 6'h1B, 6'h3F};

  task automatic rand_ops(input int n);
    logic [31:0] ra, rb;
    for (int i = 0; i < n; i++) begin
      ra = $urandom;
      rb = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      run_op(2'($urandom), flist[$urandom_range(0, 9)], ra, rb, $urandom_range(0, 2));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    sel = 0; rst_n = 0; drv_valid = 0; drv_out_ready = 0;
    drv_op = 0; drv_f = 0; drv_a = 0; drv_b = 0;
    tick(); tick();
    rst_n = 1;
    chk_reset("rst32");
    sel = 1; #1;
    chk_reset("rst8");
    sel = 0; #1;

    // 32-bit, mul/div enabled
    run_op(2'b10, 6'h22, 32'd7, 32'd9, 0);
    run_op(2'b01, 6'h00, 32'h55, 32'h55, 0);
    run_op(2'b11, 6'h00, 32'h55, 32'h55, 0);
    run_op(2'b10, 6'h2A, 32'hFFFF_FFFF, 32'd1, 0);
    run_op(2'b10, 6'h19, 32'hFFFF_FFFF, 32'd2, 1);
    run_op(2'b10, 6'h1B, 32'd100, 32'd7, 0);
    run_op(2'b10, 6'h1B, 32'd5, 32'd0, 0);
    run_op(2'b10, 6'h3F, 32'd3, 32'd4, 5);
    rand_ops(40);
    abort_op(2'b10, 6'h1B, 32'd100, 32'd7, 10);
    abort_op(2'b10, 6'h22, 32'd1, 32'd2, 1);
    run_op(2'b10, 6'h19, 32'h1234_5678, 32'h9ABC_DEF0, 0);

    // 8-bit, mul/div disabled
    sel = 1; #1;
    run_op(2'b10, 6'h19, 32'd3, 32'd4, 0);
    run_op(2'b10, 6'h1B, 32'd9, 32'd0, 0);
    run_op(2'b10, 6'h22, 32'd7, 32'd9, 0);
    run_op(2'b10, 6'h2A, 32'h80, 32'd1, 0);
    rand_ops(20);
    abort_op(2'b00, 6'h00, 32'd1, 32'd2, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/alu_ctrl_mc.md
Name: alu_ctrl_mc

Overview:
- Parametrised, multi-cycle successor to the combinational ALU-control decoder.
- Decodes aluOp/funct into the 4-bit ALU control code and executes the operation.
- Adds iterative unsigned multiply and divide, with a valid/ready handshake on input and output.
- Sits between the main control/ID stage and writeback; the core stalls on in_ready/out_valid.

Parameters:
WIDTH, 32, operand and result width (>=4)
MULDIV_EN, 1, 1 = multu/divu supported; 0 = they decode as illegal

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  synchronous active-low reset
in_valid  in  1  operation offered
in_ready  out  1  block can accept an operation
alu_op  in  2  00 add, 01 beq, 11 bne, 10 R-type (use funct)
funct  in  6  R-type function field
a  in  WIDTH  operand A (rs)
b  in  WIDTH  operand B (rt/imm)
out_valid  out  1  result available
out_ready  in  1  consumer takes result
alu_ctrl  out  4  decoded control code of the accepted op (registered)
result  out  WIDTH  ALU result / product low / quotient
result_hi  out  WIDTH  product high / remainder; 0 for single-cycle ops
cond  out  1  beq: a==b; bne: a!=b; otherwise (result==0)
illegal  out  1  unsupported funct under alu_op=10
div0  out  1  divu with b==0

Behaviour:
- Decode, alu_op=00 -> 0010 (add); 01 -> 1000 (sub, beq); 11 -> 1001 (sub, bne).
- Decode, alu_op=10 by funct: 100000 add 0010; 100010 sub 0110; 100100 and 0000; 100101 or 0001; 100110 xor 1101; 100111 nor 1100; 101010 slt 0111 (signed, result 1/0); 011001 multu 1110; 011011 divu 1111.
- Any other funct (or mul/div with MULDIV_EN=0): code 0010, add executed, illegal=1.
- Arithmetic is modulo 2^WIDTH; add/sub carry is discarded.
- FSM states: IDLE, BUSY, DONE.
  - IDLE: in_ready=1. in_valid=1 latches a, b and the decode.
  - From IDLE, single-cycle ops compute and go to DONE next edge (latency 1: out_valid high the cycle after acceptance).
  - From IDLE, multu/divu go to BUSY with step counter = 0.
  - BUSY: one shift-add (multu) or restoring-subtract (divu) step per cycle. After exactly WIDTH steps, go to DONE. Latency WIDTH+1 from acceptance to out_valid.
  - DONE: out_valid=1, all outputs held stable. On out_ready=1, go to IDLE next edge. out_valid deasserts that edge.
- in_ready=1 only in IDLE; no accept in BUSY or DONE. in_valid is ignored when in_ready=0.
- No acceptance in the same cycle DONE is left: back-to-back single-cycle ops give one result per 2 cycles.
- Operands are captured at acceptance; later changes to a/b/funct do not affect an op in flight.
- multu: {result_hi,result} = full 2*WIDTH unsigned product.
- divu: result = a/b, result_hi = a%b, unsigned.
- divu with b==0: result = all ones, result_hi = a, div0=1. Still takes WIDTH+1 cycles.
- illegal, div0, cond and alu_ctrl are valid only while out_valid=1. They are cleared on the edge leaving DONE.
- Reset values (rst_n=0 at an edge): state IDLE, out_valid 0, in_ready 1 (the cycle after reset), alu_ctrl 0010, result 0, result_hi 0, cond 0, illegal 0, div0 0, step counter 0.
- Reset mid-BUSY or in DONE aborts the op and discards the result. No out_valid follows.
- rst_n has priority over all handshakes in the same cycle.

Test Plan:
- Reset, then alu_op=10, funct=100010, a=7, b=9 accepted -> next cycle out_valid=1, alu_ctrl=0110, result=32'hFFFFFFFE, result_hi=0, cond=0.
- alu_op=01, a=b=0x55 -> alu_ctrl=1000, cond=1. Repeat with alu_op=11 -> alu_ctrl=1001, cond=0. funct=101010, a=-1, b=1 -> result=1.
- multu a=32'hFFFFFFFF, b=2 -> out_valid exactly 33 cycles after acceptance, result=32'hFFFFFFFE, result_hi=1, in_ready=0 throughout. in_valid pulses during BUSY are ignored.
- divu a=100, b=7 -> result=14, result_hi=2. divu b=0, a=5 -> result=all ones, result_hi=5, div0=1.
- funct=111111, a=3, b=4 -> illegal=1, alu_ctrl=0010, result=7. Hold out_ready=0 for 5 cycles -> outputs stable, in_ready=0. out_ready=1 -> IDLE next cycle.
- Start divu, assert rst_n=0 at step 10 -> state IDLE, out_valid never asserts, all outputs at reset values. Repeat with WIDTH=8 and MULDIV_EN=0 -> funct 011001 flags illegal.
